// File: rtl/midi_voice_alloc_if.sv
// Bundle between the MIDI receiver bitmap and the oscillator voice slots.
// master drives the bitmap and reads voices; slave is the allocator.
interface midi_voice_alloc_if #(
    parameter int NUM_VOICES = 8
);
    logic [127:0]               note_in;
    logic [127:0][2:0]          velocity_in;
    logic [NUM_VOICES-1:0]      voice_active;
    logic [NUM_VOICES-1:0][6:0] voice_note;
    logic [NUM_VOICES-1:0][2:0] voice_velocity;
    logic [NUM_VOICES-1:0]      voice_trigger;
    logic [7:0]                 drop_count;

    modport master (
        output note_in, velocity_in,
        input  voice_active, voice_note, voice_velocity,
        input  voice_trigger, drop_count
    );

    modport slave (
        input  note_in, velocity_in,
        output voice_active, voice_note, voice_velocity,
        output voice_trigger, drop_count
    );
endinterface

// File: rtl/midi_voice_alloc.sv
// Scanning polyphonic voice allocator; optional VOICE_STEAL_EN macro makes a
// note-on with no free voice steal the oldest voice instead of dropping it.
module midi_voice_alloc #(
    parameter int NUM_VOICES = 8,
    parameter int AGE_W      = 4
) (
    input  logic               clk,
    input  logic               rst,
    midi_voice_alloc_if.slave  bus
);
    logic [6:0]                       scan_idx_q, scan_idx_d;
    logic [127:0]                     note_prev_q, note_prev_d;
    logic [NUM_VOICES-1:0]            active_q, active_d;
    logic [NUM_VOICES-1:0]            trig_q, trig_d;
    logic [NUM_VOICES-1:0][6:0]       note_q, note_d;
    logic [NUM_VOICES-1:0][2:0]       vel_q, vel_d;
    logic [NUM_VOICES-1:0][AGE_W-1:0] age_q, age_d;
    logic [7:0]                       drop_q, drop_d;

    logic cur_note, prev_note, note_on, note_off;
    logic free_found, alloc_en, drop_inc;
    int   free_idx, old_idx, alloc_idx;

    assign cur_note  = bus.note_in[scan_idx_q];
    assign prev_note = note_prev_q[scan_idx_q];
    assign note_on   = cur_note & ~prev_note;
    assign note_off  = ~cur_note & prev_note;

    always_comb begin
        free_found = 1'b0;
        free_idx   = 0;
        for (int v = NUM_VOICES - 1; v >= 0; v--) begin
            if (!active_q[v]) begin
                free_found = 1'b1;
                free_idx   = v;
            end
        end
        // strict compare keeps the lowest index among equal ages
        old_idx = 0;
        for (int v = 1; v < NUM_VOICES; v++) begin
            if (age_q[v] > age_q[old_idx]) old_idx = v;
        end
    end

    always_comb begin
`ifdef VOICE_STEAL_EN
        alloc_en  = note_on;
        alloc_idx = free_found ? free_idx : old_idx;
        drop_inc  = 1'b0;
`else
        alloc_en  = note_on & free_found;
        alloc_idx = free_idx;
        drop_inc  = note_on & ~free_found;
`endif
    end

    always_comb begin
        scan_idx_d  = scan_idx_q + 7'd1;
        note_prev_d = note_prev_q;
        active_d    = active_q;
        trig_d      = '0;
        note_d      = note_q;
        vel_d       = vel_q;
        age_d       = age_q;
        drop_d      = drop_q;

        // a dropped note is still latched so it is not retried every scan
        note_prev_d[scan_idx_q] = cur_note;

        for (int v = 0; v < NUM_VOICES; v++) begin
            if (alloc_en && v == alloc_idx) begin
                active_d[v] = 1'b1;
                note_d[v]   = scan_idx_q;
                vel_d[v]    = bus.velocity_in[scan_idx_q];
                age_d[v]    = '0;
                trig_d[v]   = 1'b1;
            end else if (alloc_en && active_q[v]) begin
                if (age_q[v] != '1) age_d[v] = age_q[v] + AGE_W'(1);
            end else if (note_off && active_q[v] &&
                         note_q[v] == scan_idx_q) begin
                active_d[v] = 1'b0;
            end
        end

        if (drop_inc && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scan_idx_q  <= '0;
            note_prev_q <= '0;
            active_q    <= '0;
            trig_q      <= '0;
            note_q      <= '0;
            vel_q       <= '0;
            age_q       <= '0;
            drop_q      <= '0;
        end else begin
            scan_idx_q  <= scan_idx_d;
            note_prev_q <= note_prev_d;
            active_q    <= active_d;
            trig_q      <= trig_d;
            note_q      <= note_d;
            vel_q       <= vel_d;
            age_q       <= age_d;
            drop_q      <= drop_d;
        end
    end

    assign bus.voice_active   = active_q;
    assign bus.voice_note     = note_q;
    assign bus.voice_velocity = vel_q;
    assign bus.voice_trigger  = trig_q;
    assign bus.drop_count     = drop_q;
endmodule
